// File: rtl/aes_inv_keyexpansion_192_pkg.sv
// Shared AES key-schedule helpers: widths, Rcon table, S-box, RotWord/SubWord.
// The S-box is computed from the GF(2^8) multiplicative inverse followed by the
// AES affine map, so every expander pulls the same combinational function.
package aes_inv_keyexpansion_192_pkg;

    localparam int WORD_W   = 32;
    localparam int KEY128_W = 128;
    localparam int KEY192_W = 192;
    localparam int NR_192   = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round constant Rcon[j] = 0x01 << (j-1), j = 1..8; anything else yields 0.
    function automatic logic [7:0] rcon(input logic [5:0] j);
        logic [7:0] r;
        case (j)
            6'd1:    r = 8'h01;
            6'd2:    r = 8'h02;
            6'd3:    r = 8'h04;
            6'd4:    r = 8'h08;
            6'd5:    r = 8'h10;
            6'd6:    r = 8'h20;
            6'd7:    r = 8'h40;
            6'd8:    r = 8'h80;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = gf_xtime(t);
        end
        return p;
    endfunction

    // x^254 = x^-1 for x != 0, and 0 for x == 0 (the AES convention).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_keyexpansion_192_inv_word_gen_192.sv
// One backward AES-192 schedule step: w[k] = w[k+6] ^ f(w[k+5]).
// f applies RotWord/SubWord/Rcon only on key-column boundaries (k mod 6 == 0).
module inv_word_gen_192
    import aes_inv_keyexpansion_192_pkg::*;
(
    input  logic [5:0]  i_k,
    input  logic [31:0] i_w_k6,
    input  logic [31:0] i_w_k5,
    output logic [31:0] o_w_k
);

    logic        w_key_col;
    logic [5:0]  w_rcon_idx;
    logic [31:0] w_f;

    assign w_key_col  = ((i_k % 6'd6) == 6'd0);
    assign w_rcon_idx = (i_k + 6'd6) / 6'd6;

    // Select the schedule core for boundary words, pass-through otherwise.
    always_comb begin
        w_f = i_w_k5;
        if (w_key_col) begin
            w_f = sub_word(rot_word(i_w_k5)) ^ {rcon(w_rcon_idx), 24'h000000};
        end
    end

    assign o_w_k = i_w_k6 ^ w_f;

endmodule

// File: rtl/aes_inv_keyexpansion_192.sv
// Reverse-order AES-192 round-key generator. Holds a six-word window of the
// schedule and walks it backwards, emitting RK12 down to RK0.
// Handshake: a round key transfers on every rising edge where valid_skey and
// rk_ready are both high; subkey/rnd hold steady while valid_skey is high and
// rk_ready is low. start overrides everything, including a same-cycle transfer.
module aes_inv_keyexpansion_192
    import aes_inv_keyexpansion_192_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [191:0] last_key,
    input  logic         rk_ready,
    output logic [127:0] subkey,
    output logic [3:0]   rnd,
    output logic         valid_skey,
    output logic         busy,
    output logic         done,
    output logic         dbg_state
);

    state_t       r_state, w_state_nxt;
    logic [191:0] r_win, w_win_nxt;
    logic [3:0]   r_rnd, w_rnd_nxt;
    logic         r_done, w_done_nxt;

    logic [31:0]  w_word [6];
    logic [31:0]  w_gen_k6 [4];
    logic [31:0]  w_gen_k5 [4];
    logic [31:0]  w_new [4];
    logic [5:0]   w_k_base;
    logic         w_rk12;

    assign w_rk12   = (r_rnd == 4'd12);
    // Window base b is 4*rnd (46 at rnd 12); the new words start at 4*(rnd-1).
    assign w_k_base = {r_rnd - 4'd1, 2'b00};

    // Split the window into words; word 0 is the lowest-indexed schedule word.
    always_comb begin
        for (int j = 0; j < 6; j++) begin
            w_word[j] = r_win[191 - 32*j -: 32];
        end
    end

    // Route w[k+6]/w[k+5] to each lane; the rnd 12 step is shifted by two words.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_gen_k6[i] = w_word[2 + i];
            w_gen_k5[i] = w_word[1 + i];
        end
        if (w_rk12) begin
            w_gen_k6[0] = w_word[4];
            w_gen_k5[0] = w_word[3];
            w_gen_k6[1] = w_word[5];
            w_gen_k5[1] = w_word[4];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : gen_lane
        inv_word_gen_192 u_gen (
            .i_k    (w_k_base + 6'(g)),
            .i_w_k6 (w_gen_k6[g]),
            .i_w_k5 (w_gen_k5[g]),
            .o_w_k  (w_new[g])
        );
    end

    // Next-state, window and round-index update.
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_rnd_nxt   = r_rnd;
        w_done_nxt  = 1'b0;
        if (start) begin
            w_state_nxt = ST_RUN;
            w_win_nxt   = last_key;
            w_rnd_nxt   = 4'd12;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (rk_ready) begin
                        if (r_rnd == 4'd0) begin
                            w_state_nxt = ST_IDLE;
                            w_win_nxt   = '0;
                            w_rnd_nxt   = 4'd0;
                            w_done_nxt  = 1'b1;
                        end else if (w_rk12) begin
                            w_win_nxt = {w_new[0], w_new[1], r_win[191:64]};
                            w_rnd_nxt = 4'd11;
                        end else begin
                            w_win_nxt = {w_new[0], w_new[1], w_new[2], w_new[3],
                                         r_win[191:128]};
                            w_rnd_nxt = r_rnd - 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, window, round index and done pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_win   <= '0;
            r_rnd   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_rnd   <= w_rnd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign valid_skey = (r_state == ST_RUN);
    assign busy       = valid_skey;
    assign rnd        = r_rnd;
    assign done       = r_done;
    assign dbg_state  = r_state;
    assign subkey     = !valid_skey ? 128'h0 : (w_rk12 ? r_win[127:0] : r_win[191:64]);

endmodule

// File: tb/tb_aes_inv_keyexpansion_192.sv
// Bench for the reverse AES-192 round-key generator. Expected round keys come
// from a forward AES-192 key expansion built on a brute-force S-box table.
module tb_aes_inv_keyexpansion_192;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [191:0] last_key;
    logic         rk_ready;
    logic [127:0] subkey;
    logic [3:0]   rnd;
    logic         valid_skey;
    logic         busy;
    logic         done;
    logic         dbg_state;

    aes_inv_keyexpansion_192 dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .last_key   (last_key),
        .rk_ready   (rk_ready),
        .subkey     (subkey),
        .rnd        (rnd),
        .valid_skey (valid_skey),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic [191:0] key;
        int           rnd;
        logic [127:0] exp;
    } vec_t;

    localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [31:0]  gold_w [52];
    logic [131:0] exp_q [$];
    logic [127:0] cap [13];
    vec_t         vecs [3];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    // Forward AES-192 expansion of a cipher key into w0..w51.
    task automatic expand(input logic [191:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 6; i++) gold_w[i] = key[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = gold_w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rc = 8'h01 << (i/6 - 1);
                t[31:24] = t[31:24] ^ rc;
            end
            gold_w[i] = gold_w[i-6] ^ t;
        end
    endtask

    // Scoreboard load: expected {rnd, round key} for r = 12 down to 0.
    task automatic load_expect(input logic [191:0] key, output logic [191:0] last);
        expand(key);
        last = {gold_w[46], gold_w[47], gold_w[48], gold_w[49], gold_w[50], gold_w[51]};
        for (int r = 12; r >= 0; r--)
            exp_q.push_back({4'(r), gold_w[4*r], gold_w[4*r+1], gold_w[4*r+2], gold_w[4*r+3]});
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic drain(input int ready_pct, output int n_cycles);
        int dones = 0;
        n_cycles = 0;
        while (exp_q.size() > 0 && n_cycles < 200) begin
            if (done) dones++;
            check("subkey_seq", 192'({valid_skey, busy, rnd, subkey}), 192'({2'b11, exp_q[0]}));
            rk_ready = ($urandom_range(0, 99) < ready_pct);
            if (rk_ready) begin
                if (rnd <= 4'd12) cap[rnd] = subkey;
                void'(exp_q.pop_front());
            end
            n_cycles++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL seq_timeout: got %0d keys left expected 0", exp_q.size());
            exp_q.delete();
        end
        check("no_early_done", 192'(dones), 192'(0));
        check("done_pulse", 192'({done, valid_skey, busy, rnd, subkey}), 192'({1'b1, 134'h0}));
        rk_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_clear", 192'({done, valid_skey}), 192'(2'b00));
    endtask

    task automatic run_seq(input logic [191:0] key, input int ready_pct, output int n_cycles);
        logic [191:0] last;
        load_expect(key, last);
        start    = 1'b1;
        last_key = last;
        @(negedge clk);
        start = 1'b0;
        drain(ready_pct, n_cycles);
    endtask

    // Start a sequence and advance with rk_ready high until rnd reaches target.
    task automatic walk_to(input logic [191:0] key, input logic [3:0] target, output int dones);
        logic [191:0] last;
        int guard = 0;
        dones = 0;
        exp_q.delete();
        load_expect(key, last);
        start    = 1'b1;
        last_key = last;
        @(negedge clk);
        start = 1'b0;
        while (!(valid_skey && rnd == target) && guard < 40) begin
            if (done) dones++;
            rk_ready = 1'b1;
            @(negedge clk);
            guard++;
        end
        check("walk_reach", 192'({valid_skey, rnd}), 192'({1'b1, target}));
    endtask

    // watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int n;
        int dn;
        logic [191:0] key_a;
        logic [191:0] key_b;
        logic [191:0] last_b;

        vecs[0] = '{FIPS_KEY, 12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[1] = '{FIPS_KEY, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[2] = '{FIPS_KEY, 0,  128'h8e73b0f7da0e6452c810f32b809079e5};

        build_sbox();

        // reset
        reset    = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 192'({done, valid_skey, busy, rnd, subkey}), 192'(0));
        reset = 1'b0;
        @(negedge clk);

        // idle with rk_ready toggling and no start
        for (int i = 0; i < 20; i++) begin
            rk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_quiet", 192'({done, valid_skey, busy, rnd, subkey}), 192'(0));
        end

        // FIPS-197 A.2 vectors, rk_ready held high: latency and known round keys
        for (int v = 0; v < 3; v++) begin
            run_seq(vecs[v].key, 100, n);
            check("latency_13", 192'(n), 192'(13));
            check($sformatf("fips_rk%0d", vecs[v].rnd), 192'(cap[vecs[v].rnd]), 192'(vecs[v].exp));
        end

        // same key with 50% rk_ready: stalls must hold the key, order unchanged
        run_seq(FIPS_KEY, 50, n);
        check("stall_rk0", 192'(cap[0]), 192'(vecs[2].exp));

        // start re-asserted at rnd 5, coincident with a handshake
        key_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        walk_to(key_a, 4'd5, dn);
        check("abort_no_done", 192'(dn), 192'(0));
        exp_q.delete();
        load_expect(key_b, last_b);
        start    = 1'b1;
        last_key = last_b;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(100, n);

        // reset asserted at rnd 7, then a full clean sequence
        walk_to(key_a, 4'd7, dn);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid", 192'({done, valid_skey, busy, rnd, subkey}), 192'(0));
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_seq(key_a, 100, n);

        // random keys against the forward model
        for (int i = 0; i < 1000 && n_err < 20; i++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_seq(key_a, $urandom_range(60, 100), n);
        end

        // report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
